// File: rtl/flag_reg_stack.sv
// Multi-bit CPU flag register with per-bit write modes and a LIFO save/restore
// stack for call/return context saving. All outputs come straight from registers.
module flag_reg_stack #(
    parameter int NFLAGS = 2,
    parameter int DEPTH  = 4,
    parameter int DW     = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NFLAGS-1:0] wr_en,
    input  logic [1:0]        wr_mode,
    input  logic [NFLAGS-1:0] flag_in,
    input  logic              push,
    input  logic              pop,
    input  logic              clr_err,
    output logic [NFLAGS-1:0] flags_out,
    output logic [DW-1:0]     depth,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    // Stack entry index width; at least one bit so DEPTH=1 still has a legal select.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'b00,
        MODE_SET    = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_TOGGLE = 2'b11
    } wr_mode_t;

    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic [NFLAGS-1:0] stack_q [DEPTH];

    logic              full_w, empty_w;
    logic [NFLAGS-1:0] wr_val;
    logic              do_push, do_pop, do_xchg;
    logic              ovf_event, unf_event;
    logic              stk_we;
    logic [AW-1:0]     stk_widx;
    logic [AW-1:0]     top_idx;

    assign full_w  = (depth_q == DW'(DEPTH));
    assign empty_w = (depth_q == '0);

    assign stk_widx = depth_q[AW-1:0];
    assign top_idx  = AW'(depth_q - DW'(1));

    // Operation decode. Push+pop on an empty stack degrades to pop-while-empty.
    assign do_push   = push && !pop && !full_w;
    assign do_pop    = pop && !push && !empty_w;
    assign do_xchg   = push && pop && !empty_w;
    assign ovf_event = push && !pop && full_w;
    assign unf_event = pop && empty_w;

    // Per-bit write result; unselected bits hold.
    always_comb begin
        wr_val = flags_q;
        for (int i = 0; i < NFLAGS; i++) begin
            if (wr_en[i]) begin
                unique case (wr_mode_t'(wr_mode))
                    MODE_LOAD:   wr_val[i] = flag_in[i];
                    MODE_SET:    wr_val[i] = 1'b1;
                    MODE_CLEAR:  wr_val[i] = 1'b0;
                    MODE_TOGGLE: wr_val[i] = ~flags_q[i];
                endcase
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        flags_d     = wr_val;
        depth_d     = depth_q;
        stk_we      = 1'b0;
        overflow_d  = (overflow_q && !clr_err) || ovf_event;
        underflow_d = (underflow_q && !clr_err) || unf_event;

        if (do_pop || do_xchg) begin
            // Restoring from the stack takes priority over the live write.
            flags_d = stack_q[top_idx];
        end

        if (do_push) begin
            depth_d = depth_q + DW'(1);
            stk_we  = 1'b1;
        end else if (do_pop) begin
            depth_d = depth_q - DW'(1);
        end else if (do_xchg) begin
            stk_we  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q     <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: stack storage is deliberately not reset; its contents are meaningless until pushed.
    always_ff @(posedge CLK) begin
        if (!RESET && stk_we) begin
            // A push writes the free slot; an exchange overwrites the current top.
            if (do_xchg) begin
                stack_q[top_idx] <= flags_q;
            end else begin
                stack_q[stk_widx] <= flags_q;
            end
        end
    end

    assign flags_out = flags_q;
    assign depth     = depth_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_flag_reg_stack.sv
// Scoreboard bench for flag_reg_stack (NFLAGS=2, DEPTH=4): each cycle queues the
// expected post-edge outputs, then the owning test drains and compares them.
module tb_flag_reg_stack;

    localparam int NFLAGS = 2;
    localparam int DEPTH  = 4;
    localparam int DW     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [NFLAGS-1:0] flags;
        logic [DW-1:0]     depth;
        logic              full;
        logic              empty;
        logic              ovf;
        logic              unf;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NFLAGS-1:0] wr_en;
    logic [1:0]        wr_mode;
    logic [NFLAGS-1:0] flag_in;
    logic              push;
    logic              pop;
    logic              clr_err;
    logic [NFLAGS-1:0] flags_out;
    logic [DW-1:0]     depth;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    exp_t sb_q[$];
    obs_t obs_q[$];
    int   checks   = 0;
    int   failures = 0;

    flag_reg_stack #(.NFLAGS(NFLAGS), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .wr_en     (wr_en),
        .wr_mode   (wr_mode),
        .flag_in   (flag_in),
        .push      (push),
        .pop       (pop),
        .clr_err   (clr_err),
        .flags_out (flags_out),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t mk(input logic [NFLAGS-1:0] f, input int d,
                                input logic ov, input logic un);
        obs_t o;
        o.flags = f;
        o.depth = DW'(d);
        o.full  = (d == DEPTH);
        o.empty = (d == 0);
        o.ovf   = ov;
        o.unf   = un;
        return o;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, capture the post-edge outputs.
    task automatic cycle(input logic rst, input logic [NFLAGS-1:0] we, input logic [1:0] md,
                         input logic [NFLAGS-1:0] fin, input logic ps, input logic pp,
                         input logic ce, input obs_t exp_v, input string tag);
        exp_t e;
        @(negedge CLK);
        RESET   = rst;
        wr_en   = we;
        wr_mode = md;
        flag_in = fin;
        push    = ps;
        pop     = pp;
        clr_err = ce;
        e.v   = exp_v;
        e.tag = tag;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        obs_q.push_back({flags_out, depth, full, empty, overflow, underflow});
    endtask

    task automatic test_reset;
        exp_t e;
        obs_t o;
        cycle(1, 2'b11, 2'b01, 2'b11, 1, 0, 0, mk(2'b00, 0, 0, 0), "reset");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, mk(2'b00, 0, 0, 0), "reset_idle");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %p want %p", e.tag, o, e.v);
            end
        end
    endtask

    task automatic test_write_modes;
        exp_t e;
        obs_t o;
        cycle(0, 2'b11, 2'b00, 2'b10, 0, 0, 0, mk(2'b10, 0, 0, 0), "wr_load");
        cycle(0, 2'b01, 2'b11, 2'b00, 0, 0, 0, mk(2'b11, 0, 0, 0), "wr_toggle");
        cycle(0, 2'b10, 2'b10, 2'b00, 0, 0, 0, mk(2'b01, 0, 0, 0), "wr_clear");
        cycle(0, 2'b11, 2'b01, 2'b00, 0, 0, 0, mk(2'b11, 0, 0, 0), "wr_set");
        cycle(0, 2'b00, 2'b10, 2'b00, 0, 0, 0, mk(2'b11, 0, 0, 0), "wr_hold");
        cycle(0, 2'b11, 2'b00, 2'b01, 0, 0, 0, mk(2'b01, 0, 0, 0), "wr_load01");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %p want %p", e.tag, o, e.v);
            end
        end
    endtask

    task automatic test_push_pop_write;
        exp_t e;
        obs_t o;
        cycle(0, 2'b10, 2'b01, 2'b00, 1, 0, 0, mk(2'b11, 1, 0, 0), "push_with_write");
        cycle(0, 2'b11, 2'b10, 2'b00, 0, 1, 0, mk(2'b01, 0, 0, 0), "pop_ignores_write");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %p want %p", e.tag, o, e.v);
            end
        end
    endtask

    task automatic test_overflow_underflow;
        exp_t e;
        obs_t o;
        cycle(0, 2'b11, 2'b00, 2'b00, 0, 0, 0, mk(2'b00, 0, 0, 0), "fill_prep");
        cycle(0, 2'b11, 2'b00, 2'b01, 1, 0, 0, mk(2'b01, 1, 0, 0), "fill_push1");
        cycle(0, 2'b11, 2'b00, 2'b10, 1, 0, 0, mk(2'b10, 2, 0, 0), "fill_push2");
        cycle(0, 2'b11, 2'b00, 2'b11, 1, 0, 0, mk(2'b11, 3, 0, 0), "fill_push3");
        cycle(0, 2'b11, 2'b00, 2'b11, 1, 0, 0, mk(2'b11, 4, 0, 0), "fill_push4_full");
        cycle(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, mk(2'b11, 4, 1, 0), "push5_overflow");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, mk(2'b11, 3, 1, 0), "pop1_gets3");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, mk(2'b10, 2, 1, 0), "pop2_gets2");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, mk(2'b01, 1, 1, 0), "pop3_gets1");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, mk(2'b00, 0, 1, 0), "pop4_gets0");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, mk(2'b00, 0, 1, 1), "pop5_underflow");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, mk(2'b00, 0, 0, 0), "clr_both");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %p want %p", e.tag, o, e.v);
            end
        end
    endtask

    task automatic test_exchange;
        exp_t e;
        obs_t o;
        cycle(0, 2'b11, 2'b00, 2'b10, 0, 0, 0, mk(2'b10, 0, 0, 0), "xchg_prep_load");
        cycle(0, 2'b11, 2'b00, 2'b01, 1, 0, 0, mk(2'b01, 1, 0, 0), "xchg_prep_push");
        cycle(0, 2'b11, 2'b01, 2'b00, 1, 1, 0, mk(2'b10, 1, 0, 0), "xchg_swap");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, mk(2'b01, 0, 0, 0), "xchg_top_was_old");
        cycle(0, 2'b11, 2'b01, 2'b00, 1, 1, 0, mk(2'b11, 0, 0, 1), "xchg_empty_unf");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %p want %p", e.tag, o, e.v);
            end
        end
    endtask

    task automatic test_back_to_back_errors;
        exp_t e;
        obs_t o;
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, mk(2'b11, 0, 0, 0), "clr_unf");
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, mk(2'b11, i, 0, 0), "b2b_push");
        end
        cycle(0, 2'b00, 2'b00, 2'b00, 1, 0, 0, mk(2'b11, 4, 1, 0), "b2b_overflow");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 0, 1, mk(2'b11, 4, 0, 0), "clr_ovf_alone");
        cycle(0, 2'b00, 2'b00, 2'b00, 1, 0, 1, mk(2'b11, 4, 1, 0), "clr_vs_set_ovf");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, mk(2'b11, 3, 1, 0), "pop_to_depth3");
        cycle(1, 2'b11, 2'b01, 2'b11, 1, 0, 0, mk(2'b00, 0, 0, 0), "reset_mid_seq");
        cycle(0, 2'b00, 2'b00, 2'b00, 0, 1, 0, mk(2'b00, 0, 0, 1), "post_reset_pop");
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e.v) begin
                failures++;
                $display("FAIL %s: got %p want %p", e.tag, o, e.v);
            end
        end
    endtask

    initial begin
        RESET   = 1'b1;
        wr_en   = '0;
        wr_mode = 2'b00;
        flag_in = '0;
        push    = 1'b0;
        pop     = 1'b0;
        clr_err = 1'b0;

        test_reset();
        test_write_modes();
        test_push_pop_write();
        test_overflow_underflow();
        test_exchange();
        test_back_to_back_errors();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
